// File: rtl/adc_sum_sq_acc_pkg.sv
// Shared defaults, datapath width helpers and FSM state type for the
// ADC sum-of-squares integrator.
package adc_sum_sq_acc_pkg;

  localparam int N_SAMP_DEF = 4;
  localparam int SAMP_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;
  localparam int ACC_W      = 32;
  localparam int CNT_W      = 16;

  // Square of a signed sample never needs the top product bit:
  // the largest magnitude is (-2^(W-1))^2 = 2^(2W-2).
  function automatic int sq_width(input int samp_w);
    return 2 * samp_w - 1;
  endfunction

  // Adder tree output carries log2(N) growth bits above one square.
  function automatic int sum_width(input int n_samp, input int samp_w);
    return sq_width(samp_w) + $clog2(n_samp);
  endfunction

  localparam int SQ_W_DEF  = sq_width(SAMP_W_DEF);
  localparam int SUM_W_DEF = sum_width(N_SAMP_DEF, SAMP_W_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/adc_sum_sq_tree.sv
// Stages 1-2: per-sample square, then adder tree over the beat, with the
// beat's valid/first/last tags travelling alongside.
module adc_sum_sq_tree
  import adc_sum_sq_acc_pkg::*;
#(
  parameter int N_SAMP = N_SAMP_DEF,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int SQ_W   = sq_width(SAMP_W),
  parameter int SUM_W  = sum_width(N_SAMP, SAMP_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SAMP*SAMP_W-1:0] data,
  input  logic                     beat_vld,
  input  logic                     beat_first,
  input  logic                     beat_last,
  output logic [SUM_W-1:0]         sum,
  output logic                     sum_vld,
  output logic                     sum_first,
  output logic                     sum_last
);

  logic [N_SAMP-1:0][SQ_W-1:0] sq_d, sq_q;
  logic [SUM_W-1:0]            sum_d;
  logic [2:1]                  vld_pipe, first_pipe, last_pipe;

  for (genvar i = 0; i < N_SAMP; i++) begin : g_sq
    logic signed [2*SAMP_W-1:0] wide;
    assign wide    = (2*SAMP_W)'($signed(data[i*SAMP_W +: SAMP_W]));
    assign sq_d[i] = SQ_W'(wide * wide);
  end

  // Sum all squares of the registered beat
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_SAMP; i++) sum_d = sum_d + SUM_W'(sq_q[i]);
  end

  // Two pipeline stages: squares, then the tree sum; tags shift alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q       <= '0;
      sum        <= '0;
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
    end else begin
      sq_q       <= sq_d;
      sum        <= sum_d;
      vld_pipe   <= {vld_pipe[1], beat_vld};
      first_pipe <= {first_pipe[1], beat_first};
      last_pipe  <= {last_pipe[1], beat_last};
    end
  end

  assign sum_vld   = vld_pipe[2];
  assign sum_first = first_pipe[2];
  assign sum_last  = last_pipe[2];

endmodule

// File: rtl/adc_sum_sq_acc.sv
// Continuous sum-of-squares integrator over beats of signed ADC samples.
// A sync pulse (re)aligns integration boundaries; each integration is
// acc_len beats, and completed totals land in sum_sq_out.
module adc_sum_sq_acc
  import adc_sum_sq_acc_pkg::*;
#(
  parameter int N_SAMP = N_SAMP_DEF,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic [N_SAMP*SAMP_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic                     sync,
  input  logic [LEN_W-1:0]         acc_len,
  output logic [ACC_W-1:0]         sum_sq_out,
  output logic                     sum_sq_valid,
  output logic [CNT_W-1:0]         integ_count,
  output logic [CNT_W-1:0]         abort_count,
  output logic                     armed
);

  localparam int SUM_W = sum_width(N_SAMP, SAMP_W);

  // Worst case: longest integration of full-scale negative samples.
  localparam longint unsigned MAX_TOTAL =
    ((64'd1 << LEN_W) - 64'd1) * 64'(N_SAMP) * (64'd1 << (2*SAMP_W-2));

  if (MAX_TOTAL >= (64'd1 << ACC_W)) begin : g_bound_chk
    $error("adc_sum_sq_acc: parameters allow accumulator overflow");
  end

  logic [1:0]       rst_sync;
  logic             rst_n;
  state_t           state;
  logic [LEN_W-1:0] cnt, len_q, cnt_eff, len_eff;
  logic             accept, first, last, abort;
  logic [SUM_W-1:0] sum;
  logic             sum_vld, sum_first, sum_last;
  logic [ACC_W-1:0] acc, acc_n;

  // Reset asserts asynchronously, releases on a clock edge
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) rst_sync <= '0;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Beat tagging: a sync makes the current beat (or the next one) first
  always_comb begin
    accept  = adc_valid && (state == ST_ACC || sync);
    cnt_eff = sync ? '0 : cnt;
    first   = (cnt_eff == '0);
    len_eff = first ? ((acc_len == '0) ? LEN_W'(1) : acc_len) : len_q;
    last    = (cnt_eff == len_eff - LEN_W'(1));
    abort   = sync && (state == ST_ACC) && (cnt != '0);
  end

  // Arming FSM, beat counter, latched length and abort counter
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      cnt         <= '0;
      len_q       <= '0;
      abort_count <= '0;
    end else begin
      if (sync) begin
        state <= ST_ACC;
        armed <= 1'b1;
      end
      if (abort) abort_count <= abort_count + CNT_W'(1);
      if (accept) begin
        if (first) len_q <= len_eff;
        cnt <= last ? '0 : cnt_eff + LEN_W'(1);
      end else if (sync) begin
        cnt <= '0;
      end
    end
  end

  adc_sum_sq_tree #(
    .N_SAMP (N_SAMP),
    .SAMP_W (SAMP_W)
  ) u_tree (
    .clk        (user_clk),
    .rst_n      (rst_n),
    .data       (adc_data),
    .beat_vld   (accept),
    .beat_first (first),
    .beat_last  (last),
    .sum        (sum),
    .sum_vld    (sum_vld),
    .sum_first  (sum_first),
    .sum_last   (sum_last)
  );

  // A first-tagged beat restarts the total, dropping any aborted partial sum
  always_comb acc_n = (sum_first ? '0 : acc) + ACC_W'(sum);

  // Stage 3: accumulate and publish on the last beat of each integration
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      sum_sq_out   <= '0;
      sum_sq_valid <= 1'b0;
      integ_count  <= '0;
    end else begin
      sum_sq_valid <= 1'b0;
      if (sum_vld) begin
        acc <= acc_n;
        if (sum_last) begin
          sum_sq_out   <= acc_n;
          sum_sq_valid <= 1'b1;
          integ_count  <= integ_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/adc_sum_sq_acc.md
ADC_SUM_SQ_ACC -- requirements
Module: adc_sum_sq_acc

Interface
REQ-001 SHALL have parameter N_SAMP, default 4, samples per beat.
REQ-002 SHALL have parameter SAMP_W, default 8, signed two's-complement sample width.
REQ-003 SHALL have parameter LEN_W, default 16, integration-length width.
REQ-004 user_clk  in  1  sole clock; all logic rising-edge.
REQ-005 user_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 adc_data  in  N_SAMP*SAMP_W  samples; sample 0 in bits [SAMP_W-1:0].
REQ-007 adc_valid  in  1  adc_data holds a beat this cycle.
REQ-008 sync  in  1  one-cycle pulse; marks the current cycle's beat (if any) as first beat of a new integration.
REQ-009 acc_len  in  LEN_W  beats per integration; 0 treated as 1.
REQ-010 sum_sq_out  out  32  last completed sum of squares; feeds the software-readable status register.
REQ-011 sum_sq_valid  out  1  one-cycle pulse when sum_sq_out updates.
REQ-012 integ_count  out  16  completed integrations, wraps 65535->0.
REQ-013 abort_count  out  16  integrations discarded by early sync, wraps.
REQ-014 armed  out  1  high in ACC state.

Function
REQ-015 FSM states: IDLE (after reset, ignores beats until sync), ACC (accumulating, free-running).
REQ-016 IDLE->ACC on sync; ACC never returns to IDLE except by reset.
REQ-017 Beat accepted when adc_valid=1 and (state=ACC or sync=1).
REQ-018 acc_len sampled (0->1) on each integration's first beat; changes mid-integration have no effect.
REQ-019 Beat counter counts accepted beats; beat with count = len-1 tagged last; next accepted beat automatically tagged first (continuous integrations).
REQ-020 Stage 1 (1 cycle): each sample squared, unsigned 2*SAMP_W-1 bits ((-128)^2 = 16384).
REQ-021 Stage 2 (1 cycle): N_SAMP squares summed, 17 bits at defaults.
REQ-022 Stage 3: on first tag acc <= sum, else acc <= acc + sum; on last tag sum_sq_out <= running total including that beat, sum_sq_valid pulses, integ_count increments.
REQ-023 Latency: sum_sq_out/sum_sq_valid update on the 3rd rising edge after the final beat is sampled.
REQ-024 Accumulator 32 bits; max 65535*65536 < 2^32 at defaults, no saturation logic; non-default parameters SHALL satisfy the same bound (elaboration check).
REQ-025 sync in ACC with counted beats pending: partial sum discarded, abort_count increments, current beat starts new integration.
REQ-026 sync coincident with a last-tagged beat: beat becomes first of new integration; no completion, abort counted only if len>1.
REQ-027 sync with adc_valid=0: next accepted beat is first; same abort rule.
REQ-028 acc_len=1: every beat is first and last; one sum_sq_valid per beat.
REQ-029 sum_sq_out holds value between completions.

Reset
REQ-030 user_rst_n low: state IDLE, pipeline tags cleared, acc, sum_sq_out, integ_count, abort_count = 0, sum_sq_valid=0, armed=0, immediately.
REQ-031 Reset mid-integration discards in-flight beats; no sum_sq_valid emitted for them.
REQ-032 Release is synchronized internally (async assert, sync deassert).

Structure
REQ-033 Shared package holds N_SAMP/SAMP_W/LEN_W defaults, square/sum width constants, FSM state enum.
REQ-034 One sub-module, adc_sum_sq_tree: stages 1-2 (square and adder tree) with valid/first/last tag pipeline.

Verification
REQ-035 sync + acc_len=4, four beats all samples=1 -> sum_sq_out=16, valid 3 cycles after 4th beat, integ_count=1.
REQ-036 All samples -128, acc_len=65535, continuous -> sum_sq_out=4294901760, no wrap.
REQ-037 acc_len=8, sync after 5 beats -> abort_count=1, next output covers 8 beats from sync.
REQ-038 acc_len=0, samples {3,-4,0,0} each beat -> sum_sq_out=25 every beat.
REQ-039 Beats before first sync ignored; reset asserted 2 beats into integration -> all outputs 0, no valid pulse, IDLE.
REQ-040 acc_len changed 4->2 mid-integration -> current completes at 4, next at 2.
